mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1, memory read latency in cycles from address issue to valid M_RD; legal values 1..2.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 REQ0/REQ1  in  1  per-master burst request; held until GNTx.
REQ-005 ADDR0/ADDR1  in  17  burst base address.
REQ-006 LEN0/LEN1  in  4  burst length minus one, giving 1..16 beats.
REQ-007 WE0/WE1, E0/E1, S0/S1  in  1 each  write enable, extra (lane) mode, special (scalar read) mode.
REQ-008 POS0/POS1  in  2  lane position.
REQ-009 WDV0/WDV1, WDS0/WDS1  in  32 each  vector and scalar write data; sampled live on each beat.
REQ-010 GNT0/GNT1  out  1  one-cycle pulse when the burst is accepted.
REQ-011 BEAT0/BEAT1  out  1  high in the cycle a beat is issued; the master advances its write data on it.
REQ-012 RVALID0/RVALID1  out  1  high when RDATAx carries a read beat.
REQ-013 RDATA0/RDATA1  out  32  read data.
REQ-014 M_A 17, M_WDV 32, M_WDS 32, M_POS 2, M_WE 1, M_E 1, M_S 1  out  memory port drive.
REQ-015 M_RD  in  32  memory read data.
REQ-016 BUSY  out  1  high whenever the FSM is not IDLE.

Function
REQ-017 FSM states are IDLE, BURST and DRAIN.
REQ-018 IDLE: if any REQx is high, select the winner, latch its ADDR/LEN/WE/E/S/POS, pulse GNTx for one cycle and go to BURST the next cycle.
REQ-019 Arbitration is round-robin: on simultaneous requests the master not granted last wins; after reset master 0 has priority.
REQ-020 BURST: issue one beat per cycle, beat k with M_A = base + k mod 2^17 (wraps 0x1FFFF -> 0x00000); assert BEATx.
REQ-021 BURST drive: M_WE, M_E, M_S, M_POS = latched values; M_WDV/M_WDS = winner's live WDVx/WDSx.
REQ-022 After beat LEN: a write burst goes to IDLE; a read burst goes to DRAIN.
REQ-023 DRAIN holds for RD_LAT cycles, then goes to IDLE.
REQ-024 A new grant is possible only from IDLE, so consecutive bursts are separated by at least one idle cycle.
REQ-025 For each read beat, RVALIDx asserts exactly RD_LAT cycles after issue with RDATAx = M_RD; RDATA of the non-owner is 0.
REQ-026 M_WE is 0 in IDLE and DRAIN; M_A/M_WDV/M_WDS are 0 outside BURST.
REQ-027 Deasserting REQx mid-burst is ignored; the burst completes all LEN+1 beats.
REQ-028 Input changes to ADDR/LEN/WE/E/S/POS after GNT have no effect on the current burst.

Reset
REQ-029 RST drives the FSM to IDLE and the round-robin pointer to favour master 0.
REQ-030 RST zeroes all outputs and flushes the read-valid pipeline.
REQ-031 RST mid-burst or mid-DRAIN aborts with no further BEAT or RVALID; the first grant is possible the cycle after RST deasserts.

Structure
REQ-032 Package MEM_ARB_PKG holds the state enum and constants ADDR_W=17, DATA_W=32, LEN_W=4.
REQ-033 Sub-module mem_arb_rdpipe holds the RD_LAT-deep valid/owner shift register; the rest is a single module.

Verification
REQ-034 REQ0 only, ADDR0=0x00010, LEN0=3, WE0=1 -> GNT0 one cycle; M_A 0x10..0x13 on 4 consecutive cycles with M_WE=1 and BEAT0 each; then IDLE.
REQ-035 REQ1 read, ADDR1=0x1FFFE, LEN1=2, RD_LAT=1 -> M_A 0x1FFFE, 0x1FFFF, 0x00000; RVALID1 three cycles, each one cycle after its beat, RDATA1=M_RD.
REQ-036 REQ0 and REQ1 high together, repeatedly, after reset -> grants alternate 0,1,0,1 with one idle cycle between bursts.
REQ-037 REQ0 dropped after GNT0 with LEN0=15 -> 16 beats still issued.
REQ-038 RST asserted during beat 2 of a 5-beat read -> next cycle all outputs 0, BUSY=0, no RVALID; a fresh REQ1 is granted the cycle after RST deasserts.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths and FSM state encoding for the two-master memory arbiter
package mem_arb_pkg;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int LEN_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;
endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: one master's burst request, write data and read return channel
interface mem_arb_if;
  import mem_arb_pkg::*;
  logic req, we, e, s, gnt, beat, rvalid;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0] len;
  logic [1:0] pos;
  logic [DATA_W-1:0] wdv, wds, rdata;
  modport master (output req, addr, len, we, e, s, pos, wdv, wds, input gnt, beat, rvalid, rdata);
  modport slave (input req, addr, len, we, e, s, pos, wdv, wds, output gnt, beat, rvalid, rdata);
endinterface

// File: rtl/mem_arb_rdpipe.sv
// mem_arb_rdpipe: RD_LAT-deep shift of read-issue valid and owning master
module mem_arb_rdpipe #(parameter int RD_LAT = 1) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_owner,
  output logic o_valid,
  output logic o_owner
);
  logic [RD_LAT-1:0] r_v, r_o;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      r_o <= '0;
    end else begin
      r_v <= RD_LAT'({r_v, i_valid});
      r_o <= RD_LAT'({r_o, i_owner});
    end
  end
  assign o_valid = r_v[RD_LAT-1];
  assign o_owner = r_o[RD_LAT-1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master burst arbiter driving a single memory port
module mem_arbiter import mem_arb_pkg::*; #(parameter int RD_LAT = 1) (
  input  logic              clk,
  input  logic              rst,
  mem_arb_if.slave          m0,
  mem_arb_if.slave          m1,
  output logic [ADDR_W-1:0] o_m_a,
  output logic [DATA_W-1:0] o_m_wdv,
  output logic [DATA_W-1:0] o_m_wds,
  output logic [1:0]        o_m_pos,
  output logic              o_m_we,
  output logic              o_m_e,
  output logic              o_m_s,
  input  logic [DATA_W-1:0] i_m_rd,
  output logic              o_busy
);
  state_t r_state, w_next;
  logic r_owner, r_last, r_we, r_e, r_s;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0] r_len, r_cnt;
  logic [1:0] r_pos;
  logic w_any, w_win, w_grant, w_burst, w_last_beat, w_rv, w_rv_owner;
  assign w_any = m0.req | m1.req;
  assign w_win = (m0.req & m1.req) ? ~r_last : m1.req;
  assign w_burst = r_state == S_BURST;
  assign w_grant = (r_state == S_IDLE) & w_any & ~rst;
  assign w_last_beat = r_cnt == r_len;
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == S_IDLE  ? (w_any ? S_BURST : S_IDLE) :
             r_state == S_BURST ? (w_last_beat ? (r_we ? S_IDLE : S_DRAIN) : S_BURST) :
             (r_cnt == LEN_W'(RD_LAT - 1) ? S_IDLE : S_DRAIN);
  end
  // r_cnt is the beat index in BURST and the elapsed-latency count in DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= 1'b0;
      r_last <= 1'b1;
      r_addr <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_we <= 1'b0;
      r_e <= 1'b0;
      r_s <= 1'b0;
      r_pos <= '0;
    end else if (w_grant) begin
      r_owner <= w_win;
      r_last <= w_win;
      r_addr <= w_win ? m1.addr : m0.addr;
      r_len <= w_win ? m1.len : m0.len;
      r_we <= w_win ? m1.we : m0.we;
      r_e <= w_win ? m1.e : m0.e;
      r_s <= w_win ? m1.s : m0.s;
      r_pos <= w_win ? m1.pos : m0.pos;
      r_cnt <= '0;
    end else if (w_burst) begin
      r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
    end else if (r_state == S_DRAIN) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
  mem_arb_rdpipe #(.RD_LAT(RD_LAT)) u_rdpipe (
    .clk(clk),
    .rst(rst),
    .i_valid(w_burst & ~r_we),
    .i_owner(r_owner),
    .o_valid(w_rv),
    .o_owner(w_rv_owner)
  );
  always_comb begin
    m0.gnt = w_grant & ~w_win;
    m1.gnt = w_grant & w_win;
    m0.beat = w_burst & ~r_owner;
    m1.beat = w_burst & r_owner;
    m0.rvalid = w_rv & ~w_rv_owner;
    m1.rvalid = w_rv & w_rv_owner;
    m0.rdata = (w_rv & ~w_rv_owner) ? i_m_rd : '0;
    m1.rdata = (w_rv & w_rv_owner) ? i_m_rd : '0;
    o_m_a = w_burst ? r_addr + ADDR_W'(r_cnt) : '0;
    o_m_wdv = w_burst ? (r_owner ? m1.wdv : m0.wdv) : '0;
    o_m_wds = w_burst ? (r_owner ? m1.wds : m0.wds) : '0;
    o_m_pos = w_burst ? r_pos : '0;
    o_m_we = w_burst & r_we;
    o_m_e = w_burst & r_e;
    o_m_s = w_burst & r_s;
    o_busy = r_state != S_IDLE;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, corner sequences and a randomized schedule model for mem_arbiter
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int LAT = 1;
  localparam int NC = 400;
  logic clk = 1'b0, rst = 1'b1;
  logic [ADDR_W-1:0] m_a;
  logic [DATA_W-1:0] m_wdv, m_wds, m_rd;
  logic [1:0] m_pos;
  logic m_we, m_e, m_s, busy;
  int n_chk = 0, n_fail = 0;
  mem_arb_if u_m0 ();
  mem_arb_if u_m1 ();
  mem_arbiter #(.RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .m0(u_m0), .m1(u_m1),
    .o_m_a(m_a), .o_m_wdv(m_wdv), .o_m_wds(m_wds), .o_m_pos(m_pos),
    .o_m_we(m_we), .o_m_e(m_e), .o_m_s(m_s), .i_m_rd(m_rd), .o_busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic m; logic [16:0] addr; logic [3:0] len; logic we;
    logic [16:0] first_a, last_a; int beats, rvs;
  } vec_t;
  typedef struct {
    logic gnt0, gnt1, beat, owner, rv, rv_owner, busy, we;
    logic [3:0] attr; logic [16:0] a;
  } exp_t;
  vec_t tbl[6];
  exp_t ex[NC+40];
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic m, input logic req, input logic [16:0] a, input logic [3:0] l,
                       input logic we, input logic [3:0] attr);
    if (m) begin
      u_m1.req = req; u_m1.addr = a; u_m1.len = l; u_m1.we = we; {u_m1.e, u_m1.s, u_m1.pos} = attr;
    end else begin
      u_m0.req = req; u_m0.addr = a; u_m0.len = l; u_m0.we = we; {u_m0.e, u_m0.s, u_m0.pos} = attr;
    end
  endtask
  task automatic live_data;
    u_m0.wdv = $urandom; u_m0.wds = $urandom;
    u_m1.wdv = $urandom; u_m1.wds = $urandom;
    m_rd = $urandom;
  endtask
  function automatic logic gnt_of(input logic m); return m ? u_m1.gnt : u_m0.gnt; endfunction
  function automatic logic beat_of(input logic m); return m ? u_m1.beat : u_m0.beat; endfunction
  function automatic logic rv_of(input logic m); return m ? u_m1.rvalid : u_m0.rvalid; endfunction
  function automatic logic [31:0] rdata_of(input logic m); return m ? u_m1.rdata : u_m0.rdata; endfunction
  function automatic logic [31:0] wdv_of(input logic m); return m ? u_m1.wdv : u_m0.wdv; endfunction
  function automatic logic [31:0] wds_of(input logic m); return m ? u_m1.wds : u_m0.wds; endfunction
  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      step;
    end
    chk(name, i < 40, 1);
  endtask
  // one burst; request and attributes are scrambled right after the grant
  task automatic run_vec(input vec_t v);
    int beats = 0, rvs = 0, i;
    logic [16:0] first_a = '0, last_a = '0;
    logic got = 1'b0, attr_ok = 1'b1, data_ok = 1'b1;
    step; live_data;
    drive(v.m, 1'b1, v.addr, v.len, v.we, 4'b1011);
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      got = gnt_of(v.m);
      if (!got) begin step; live_data; end
    end
    chk("vec gnt", got, 1);
    step; live_data;
    drive(v.m, 1'b0, ~v.addr, ~v.len, ~v.we, 4'b0100);
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      if (beat_of(v.m)) begin
        if (beats == 0) first_a = m_a;
        last_a = m_a;
        beats++;
        if (m_we !== v.we || {m_e, m_s, m_pos} !== 4'b1011) attr_ok = 1'b0;
        if (m_wdv !== wdv_of(v.m) || m_wds !== wds_of(v.m)) data_ok = 1'b0;
      end
      if (rv_of(v.m)) begin
        rvs++;
        if (rdata_of(v.m) !== m_rd) data_ok = 1'b0;
      end
      step; live_data;
    end
    chk("vec done", i < 40, 1);
    chk("vec first_a", first_a, v.first_a);
    chk("vec last_a", last_a, v.last_a);
    chk("vec beats", beats, v.beats);
    chk("vec rvalids", rvs, v.rvs);
    chk("vec attrs", attr_ok, 1);
    chk("vec data", data_ok, 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic rq[2], wr[2], gp[2];
    logic [16:0] ad[2];
    logic [3:0] ln[2], at[2];
    logic last, win;
    int free_at;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
    live_data;
    step;
    u_m0.req = 1'b1;
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst m_a", m_a, 0);
    chk("rst m_we", m_we, 0);
    chk("rst gnt0", u_m0.gnt, 0);
    chk("rst beat0", u_m0.beat, 0);
    chk("rst rvalid1", u_m1.rvalid, 0);
    chk("rst rdata0", u_m0.rdata, 0);
    step;
    u_m0.req = 1'b0;
    rst = 1'b0;
    tbl[0] = '{1'b0, 17'h00010, 4'd3,  1'b1, 17'h00010, 17'h00013, 4, 0};
    tbl[1] = '{1'b1, 17'h1FFFE, 4'd2,  1'b0, 17'h1FFFE, 17'h00000, 3, 3};
    tbl[2] = '{1'b0, 17'h1FFFF, 4'd0,  1'b1, 17'h1FFFF, 17'h1FFFF, 1, 0};
    tbl[3] = '{1'b0, 17'h00000, 4'd15, 1'b1, 17'h00000, 17'h0000F, 16, 0};
    tbl[4] = '{1'b1, 17'h1FFF8, 4'd15, 1'b0, 17'h1FFF8, 17'h00007, 16, 16};
    tbl[5] = '{1'b1, 17'h0ABCD, 4'd0,  1'b0, 17'h0ABCD, 17'h0ABCD, 1, 1};
    for (int t = 0; t < 6; t++) run_vec(tbl[t]);
    // both masters requesting continuously alternate, with the idle/grant cycle between bursts
    step; rst = 1'b1;
    drive(1'b0, 1'b1, 17'h00100, 4'd0, 1'b1, '0);
    drive(1'b1, 1'b1, 17'h00200, 4'd0, 1'b1, '0);
    step; rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("alt gnt0", u_m0.gnt, c % 4 == 0);
      chk("alt gnt1", u_m1.gnt, c % 4 == 2);
      step;
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
    wait_idle("alt idle");
    // reset during beat 2 of a 5-beat read
    step;
    drive(1'b0, 1'b1, 17'h00100, 4'd4, 1'b0, '0);
    @(negedge clk);
    chk("rstb gnt0", u_m0.gnt, 1);
    step;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    step;
    step;
    rst = 1'b1;
    drive(1'b1, 1'b1, 17'h00200, 4'd1, 1'b1, '0);
    @(negedge clk);
    chk("rstb beat2", u_m0.beat, 1);
    chk("rstb beat2 addr", m_a, 17'h00102);
    step;
    @(negedge clk);
    chk("rstb busy", busy, 0);
    chk("rstb beat0", u_m0.beat, 0);
    chk("rstb rvalid0", u_m0.rvalid, 0);
    chk("rstb rdata0", u_m0.rdata, 0);
    chk("rstb m_a", m_a, 0);
    chk("rstb gnt1 held", u_m1.gnt, 0);
    step;
    rst = 1'b0;
    @(negedge clk);
    chk("rstb gnt1", u_m1.gnt, 1);
    step;
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    chk("rstb beat1", u_m1.beat, 1);
    chk("rstb beat1 addr", m_a, 17'h00200);
    wait_idle("rstb idle");
    // randomized traffic against a burst-schedule model
    step; rst = 1'b1;
    step; rst = 1'b0;
    for (int i = 0; i < NC + 40; i++) ex[i] = '{default: '0};
    for (int m = 0; m < 2; m++) begin rq[m] = 1'b0; gp[m] = 1'b0; end
    free_at = 0;
    last = 1'b1;
    for (int c = 0; c < NC; c++) begin
      step; live_data;
      for (int m = 0; m < 2; m++) begin
        if (gp[m] || !rq[m]) begin
          ad[m] = 17'($urandom);
          ln[m] = 4'($urandom);
          wr[m] = 1'($urandom);
          at[m] = 4'($urandom);
          rq[m] = gp[m] ? ($urandom_range(3) == 0) : ($urandom_range(2) == 0);
        end
        gp[m] = 1'b0;
        drive(m[0], rq[m], ad[m], ln[m], wr[m], at[m]);
      end
      if (c >= free_at && (rq[0] || rq[1])) begin
        win = (rq[0] && rq[1]) ? ~last : rq[1];
        last = win;
        gp[win] = 1'b1;
        if (win) ex[c].gnt1 = 1'b1;
        else ex[c].gnt0 = 1'b1;
        for (int k = 0; k <= int'(ln[win]); k++) begin
          ex[c+1+k].beat = 1'b1;
          ex[c+1+k].owner = win;
          ex[c+1+k].a = ad[win] + 17'(k);
          ex[c+1+k].we = wr[win];
          ex[c+1+k].attr = at[win];
          if (!wr[win]) begin
            ex[c+1+k+LAT].rv = 1'b1;
            ex[c+1+k+LAT].rv_owner = win;
          end
        end
        free_at = c + int'(ln[win]) + 2 + (wr[win] ? 0 : LAT);
        for (int t = c + 1; t < free_at; t++) ex[t].busy = 1'b1;
      end
      @(negedge clk);
      chk("rnd gnt0", u_m0.gnt, ex[c].gnt0);
      chk("rnd gnt1", u_m1.gnt, ex[c].gnt1);
      chk("rnd beat0", u_m0.beat, ex[c].beat & ~ex[c].owner);
      chk("rnd beat1", u_m1.beat, ex[c].beat & ex[c].owner);
      chk("rnd m_a", m_a, ex[c].a);
      chk("rnd m_we", m_we, ex[c].beat & ex[c].we);
      chk("rnd attr", {m_e, m_s, m_pos}, ex[c].beat ? ex[c].attr : 4'b0);
      chk("rnd m_wdv", m_wdv, ex[c].beat ? wdv_of(ex[c].owner) : 32'h0);
      chk("rnd m_wds", m_wds, ex[c].beat ? wds_of(ex[c].owner) : 32'h0);
      chk("rnd busy", busy, ex[c].busy);
      chk("rnd rvalid0", u_m0.rvalid, ex[c].rv & ~ex[c].rv_owner);
      chk("rnd rvalid1", u_m1.rvalid, ex[c].rv & ex[c].rv_owner);
      chk("rnd rdata0", u_m0.rdata, (ex[c].rv & ~ex[c].rv_owner) ? m_rd : 32'h0);
      chk("rnd rdata1", u_m1.rdata, (ex[c].rv & ex[c].rv_owner) ? m_rd : 32'h0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
